vend_session_timer: RTL
=======================

Name: vend_session_timer

Overview:
- Per-second session supervisor alongside the coin-accumulation FSM, in the 1 Hz domain.
- Tracks seconds since the last customer activity. Raises a warning before the idle limit, then expiry with a one-shot refund request carrying the stranded credit.
- Also stretches the vend output into a multi-second lamp drive.
- Every coin/stop event pulses rstCounter, which restarts the session.

Parameters:
- TIMEOUT_S, 30, idle seconds until expiry; must be < 2**CNT_W
- WARN_S, 25, elapsed seconds at which warn asserts; must be < TIMEOUT_S
- VEND_HOLD_S, 3, seconds vend_lamp stays lit after a vend
- CNT_W, 5, width of elapsed/secs_left
- CREDIT_W, 5, width of credit/refund_value

Ports:
- clk1sec  in  1  1 Hz clock from divider
- rstCounter  in  1  reset, asynchronous, active-high; pulsed on every coin/stop event
- credit  in  CREDIT_W  running credit from coin FSM; quasi-static, sampled on clk1sec
- vend  in  1  vend level from coin FSM
- elapsed  out  CNT_W  seconds idle in current session
- secs_left  out  CNT_W  countdown for display
- warn  out  1  approaching timeout
- timeout  out  1  session expired (level)
- refund_valid  out  1  one-cycle refund request
- refund_value  out  CREDIT_W  credit to refund, valid with refund_valid
- vend_lamp  out  1  stretched vend indicator

Behaviour:
- Reset (async, rstCounter=1) forces:
  - FSM=IDLE; elapsed=0; secs_left=TIMEOUT_S
  - warn=0, timeout=0, refund_valid=0, refund_value=0
  - hold_cnt=0, vend_lamp=0, vend_d=0
- All logic is clocked on posedge clk1sec; no other clock is used.
- FSM states: IDLE, ARMED, WARN, EXPIRED.
  - IDLE: elapsed held 0. Moves to ARMED when credit!=0. elapsed is not incremented in the sampling cycle.
  - ARMED: elapsed+=1 per cycle.
    - credit==0 -> IDLE, elapsed=0.
    - elapsed+1==WARN_S -> WARN, warn=1 registered with the same edge.
  - WARN: elapsed+=1 per cycle, warn=1.
    - credit==0 -> IDLE, warn=0, elapsed=0.
    - elapsed+1==TIMEOUT_S -> EXPIRED, with the same edge setting:
      - elapsed=TIMEOUT_S
      - timeout=1, warn=0
      - refund_valid=1 for exactly one cycle
      - refund_value=credit sampled at that edge
  - EXPIRED: terminal until rstCounter.
    - timeout stays 1.
    - elapsed saturates at TIMEOUT_S.
    - refund_value holds its value; refund_valid=0 after the first cycle.
    - credit changes are ignored.
- secs_left: TIMEOUT_S in IDLE; TIMEOUT_S-elapsed in ARMED/WARN; 0 in EXPIRED. Never wraps.
- Credit priority: credit==0 checked before the threshold compares. Credit dropping to 0 on the expiry edge -> IDLE, no refund.
- Vend lamp:
  - vend_d<=vend every cycle.
  - On rising edge (vend & ~vend_d), hold_cnt<=VEND_HOLD_S. Otherwise, if hold_cnt!=0, hold_cnt decrements.
  - vend_lamp = (hold_cnt!=0), registered.
  - vend_d resets to 0, so a vend still high after a reset pulse is seen as a new rising edge. This is intended: the vend coincides with a coin-event reset.
  - A new edge while lit reloads to VEND_HOLD_S.
  - The lamp runs independently of the session FSM and of timeout.
- Reset mid-session: all state is cleared immediately and the session restarts from IDLE at the next edge. A pending refund is discarded.

Optional Feature:
- Macro: VEND_WARN_BLINK_EN.
- Defined:
  - In WARN, warn toggles every clk1sec cycle, starting at 1 on entry to WARN, giving a 0.5 Hz blink.
  - Forced 0 on any exit from WARN.
- Undefined: warn is a steady level for the whole of WARN.
- No other outputs are affected.

Test Plan:
1. rstCounter=1 then 0, credit=0 for 40 cycles -> IDLE throughout; elapsed=0, secs_left=30, all flags 0.
2. Credit path:
   - Reset released, credit=7 held.
   - ARMED on the 1st edge.
   - warn=1 after the edge where elapsed becomes 25.
   - On the edge where elapsed becomes 30: timeout=1, refund_valid=1 for exactly one cycle, refund_value=7, secs_left=0.
   - After 10 further cycles: timeout still 1, elapsed=30.
3. credit=7, run to elapsed=26 (warn=1), then credit=0 -> next edge IDLE; elapsed=0, warn=0, no refund_valid.
4. credit=12, elapsed=20, then a 1-cycle rstCounter pulse -> all outputs at reset values at once. With credit still 12, elapsed counts again from 0 and expires 30 cycles after re-arm.
5. Vend lamp:
   - vend rises together with a rstCounter pulse and stays high -> vend_lamp=1 for 3 cycles after reset release, then 0.
   - vend dropping and rising again while lit -> lamp stays lit for 3 cycles from the new edge.
6. With VEND_WARN_BLINK_EN defined, credit=5:
   - warn = 1,0,1,0,1 over the 5 WARN cycles.
   - warn=0 and timeout=1 at expiry.
   - Without the macro: warn=1 for all 5 cycles.

Source files
------------

// File: rtl/vend_session_timer.sv
`default_nettype none
// ============================================================================
// Module   : vend_session_timer
// Brief    : 1 Hz session idle supervisor with warn/expiry/refund and
//            stretched vend lamp. Optional macro VEND_WARN_BLINK_EN makes
//            warn blink at 0.5 Hz while in the warning window.
// Revision : 1.0 - initial release
// ============================================================================
module vend_session_timer #(
    parameter int TIMEOUT_S   = 30,
    parameter int WARN_S      = 25,
    parameter int VEND_HOLD_S = 3,
    parameter int CNT_W       = 5,
    parameter int CREDIT_W    = 5
) (
    input  logic                clk1sec,
    input  logic                rstCounter,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                vend,
    output logic [CNT_W-1:0]    elapsed,
    output logic [CNT_W-1:0]    secs_left,
    output logic                warn,
    output logic                timeout,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_value,
    output logic                vend_lamp
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_WARN    = 2'd2;
    localparam logic [1:0] c_EXPIRED = 2'd3;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_S);
    localparam logic [CNT_W-1:0] c_WARN_AT = CNT_W'(WARN_S);
    localparam int               c_HOLD_W  = (VEND_HOLD_S < 1) ? 1 : $clog2(VEND_HOLD_S + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD = c_HOLD_W'(VEND_HOLD_S);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_elapsed;
    logic [CNT_W-1:0]    w_elapsed_nxt;
    logic [CNT_W-1:0]    w_elapsed_inc;
    logic [CNT_W-1:0]    r_secs_left;
    logic [CNT_W-1:0]    w_secs_left_nxt;
    logic                r_warn;
    logic                w_warn_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic                r_refund_valid;
    logic                w_refund_valid_nxt;
    logic [CREDIT_W-1:0] r_refund_value;
    logic [CREDIT_W-1:0] w_refund_value_nxt;
    logic                w_credit_zero;

    logic                r_vend_d;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_vend_lamp;

    assign w_credit_zero = (credit == '0);
    assign w_elapsed_inc = r_elapsed + CNT_W'(1);

    // State and registered session outputs
    always_ff @(posedge clk1sec or posedge rstCounter) begin
        if (rstCounter) begin
            r_state        <= c_IDLE;
            r_elapsed      <= '0;
            r_secs_left    <= c_TIMEOUT;
            r_warn         <= 1'b0;
            r_timeout      <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_value <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_elapsed      <= w_elapsed_nxt;
            r_secs_left    <= w_secs_left_nxt;
            r_warn         <= w_warn_nxt;
            r_timeout      <= w_timeout_nxt;
            r_refund_valid <= w_refund_valid_nxt;
            r_refund_value <= w_refund_value_nxt;
        end
    end

    // Credit loss takes priority over the threshold compares
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_credit_zero) begin
                    w_state_nxt = c_ARMED;
                end
            end
            c_ARMED: begin
                if (w_credit_zero) begin
                    w_state_nxt = c_IDLE;
                end else if (w_elapsed_inc == c_WARN_AT) begin
                    w_state_nxt = c_WARN;
                end
            end
            c_WARN: begin
                if (w_credit_zero) begin
                    w_state_nxt = c_IDLE;
                end else if (w_elapsed_inc == c_TIMEOUT) begin
                    w_state_nxt = c_EXPIRED;
                end
            end
            c_EXPIRED: begin
                w_state_nxt = c_EXPIRED;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_elapsed_nxt      = r_elapsed;
        w_warn_nxt         = 1'b0;
        w_timeout_nxt      = 1'b0;
        w_refund_valid_nxt = 1'b0;
        w_refund_value_nxt = r_refund_value;
        case (w_state_nxt)
            c_IDLE: begin
                w_elapsed_nxt = '0;
            end
            c_ARMED: begin
                // The arming edge only samples credit; counting starts next edge
                w_elapsed_nxt = (r_state == c_IDLE) ? '0 : w_elapsed_inc;
            end
            c_WARN: begin
                w_elapsed_nxt = w_elapsed_inc;
`ifdef VEND_WARN_BLINK_EN
                w_warn_nxt    = (r_state == c_WARN) ? ~r_warn : 1'b1;
`else
                w_warn_nxt    = 1'b1;
`endif
            end
            c_EXPIRED: begin
                w_elapsed_nxt = c_TIMEOUT;
                w_timeout_nxt = 1'b1;
                if (r_state == c_WARN) begin
                    w_refund_valid_nxt = 1'b1;
                    w_refund_value_nxt = credit;
                end
            end
            default: begin
                w_elapsed_nxt = '0;
            end
        endcase
        w_secs_left_nxt = (w_state_nxt == c_EXPIRED) ? '0 : (c_TIMEOUT - w_elapsed_nxt);
    end

    // Vend lamp stretcher, independent of the session state
    always_comb begin
        w_hold_nxt = r_hold_cnt;
        if (vend && !r_vend_d) begin
            w_hold_nxt = c_HOLD;
        end else if (r_hold_cnt != '0) begin
            w_hold_nxt = r_hold_cnt - c_HOLD_W'(1);
        end
    end

    always_ff @(posedge clk1sec or posedge rstCounter) begin
        if (rstCounter) begin
            r_vend_d    <= 1'b0;
            r_hold_cnt  <= '0;
            r_vend_lamp <= 1'b0;
        end else begin
            r_vend_d    <= vend;
            r_hold_cnt  <= w_hold_nxt;
            r_vend_lamp <= (w_hold_nxt != '0);
        end
    end

    assign elapsed      = r_elapsed;
    assign secs_left    = r_secs_left;
    assign warn         = r_warn;
    assign timeout      = r_timeout;
    assign refund_valid = r_refund_valid;
    assign refund_value = r_refund_value;
    assign vend_lamp    = r_vend_lamp;

endmodule
`default_nettype wire
